// File: rtl/serdesphy_ana_serializer_p_if.sv
`default_nettype none
// ============================================================================
// Module   : serdesphy_ana_serializer_p_if
// Brief    : Word handshake between the TX framer and the serializer.
// Revision : 1.0 - initial release
// ============================================================================
interface serdesphy_ana_serializer_p_if #(
  parameter int DATA_W = 16
);
  logic              load_data;
  logic [DATA_W-1:0] parallel_in;
  logic              data_ready;

  modport master (output load_data, output parallel_in, input data_ready);
  modport slave  (input load_data, input parallel_in, output data_ready);
endinterface
`default_nettype wire

// File: rtl/serdesphy_ana_serializer_p.sv
`default_nettype none
// ============================================================================
// Module   : serdesphy_ana_serializer_p
// Brief    : Double-buffered parallel-to-serial converter with idle fill.
// Revision : 1.0 - initial release
// ============================================================================
module serdesphy_ana_serializer_p #(
  parameter int          DATA_W    = 16,
  parameter bit          MSB_FIRST = 1'b0,
  parameter logic [63:0] IDLE_WORD = 64'h5555,
  parameter bit          INVERT    = 1'b0
) (
  input  wire                          clk_240m,
  input  wire                          rst,
  input  wire                          enable,
  serdesphy_ana_serializer_p_if.slave  tx_if,
  output logic                         serial_out,
  output logic                         busy,
  output logic                         underrun,
  output logic [7:0]                   underrun_count
);

  localparam int                 c_cnt_w     = $clog2(DATA_W);
  localparam logic [c_cnt_w-1:0] c_last      = c_cnt_w'(DATA_W - 1);
  localparam logic [DATA_W-1:0]  c_idle_word = IDLE_WORD[DATA_W-1:0];

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]         r_state;
  logic [0:0]         w_next_state;
  logic [DATA_W-1:0]  r_hold;
  logic               r_hold_valid;
  logic [DATA_W-1:0]  r_sr;
  logic [c_cnt_w-1:0] r_bit_cnt;
  logic               r_underrun;
  logic [7:0]         r_underrun_count;

  logic               w_data_ready;
  logic               w_accept;
  logic               w_boundary;
  logic               w_refill;
  logic               w_starve;
  logic               w_cur_bit;
  logic [DATA_W-1:0]  w_sr_shift;

  // The output end of the shift register depends on the bit order.
  if (MSB_FIRST) begin : g_msb_first
    assign w_cur_bit  = r_sr[DATA_W-1];
    assign w_sr_shift = {r_sr[DATA_W-2:0], 1'b0};
  end else begin : g_lsb_first
    assign w_cur_bit  = r_sr[0];
    assign w_sr_shift = {1'b0, r_sr[DATA_W-1:1]};
  end

  assign w_accept   = tx_if.load_data & w_data_ready;
  assign w_boundary = (r_state == S_RUN) && (r_bit_cnt == c_last);
  assign w_refill   = r_hold_valid && ((r_state == S_IDLE) || w_boundary);
  assign w_starve   = w_boundary && !r_hold_valid;

  always_ff @(posedge clk_240m or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (!enable) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (r_hold_valid) w_next_state = S_RUN;
        S_RUN:   w_next_state = S_RUN;
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy         = (r_state == S_RUN);
    w_data_ready = enable & ~r_hold_valid;
    serial_out   = w_cur_bit ^ INVERT;
  end

  assign tx_if.data_ready = w_data_ready;
  assign underrun         = r_underrun;
  assign underrun_count   = r_underrun_count;

  // Accept and refill are exclusive: accept needs an empty holding register.
  always_ff @(posedge clk_240m or posedge rst) begin
    if (rst) begin
      r_hold           <= '0;
      r_hold_valid     <= 1'b0;
      r_sr             <= '0;
      r_bit_cnt        <= '0;
      r_underrun       <= 1'b0;
      r_underrun_count <= '0;
    end else if (!enable) begin
      r_hold_valid     <= 1'b0;
      r_sr             <= '0;
      r_bit_cnt        <= '0;
      r_underrun       <= 1'b0;
      r_underrun_count <= '0;
    end else begin
      r_underrun <= 1'b0;
      if (w_accept) begin
        r_hold       <= tx_if.parallel_in;
        r_hold_valid <= 1'b1;
      end
      if (w_refill) begin
        r_sr         <= r_hold;
        r_hold_valid <= 1'b0;
        r_bit_cnt    <= '0;
      end else if (w_starve) begin
        r_sr       <= c_idle_word;
        r_bit_cnt  <= '0;
        r_underrun <= 1'b1;
        if (r_underrun_count != 8'hFF) begin
          r_underrun_count <= r_underrun_count + 8'd1;
        end
      end else if (r_state == S_RUN) begin
        r_sr      <= w_sr_shift;
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serdesphy_ana_serializer_p.sv
`default_nettype none
// ============================================================================
// Module   : tb_serdesphy_ana_serializer_p
// Brief    : Self-checking bench: word table, per-cycle scoreboard, corners.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serdesphy_ana_serializer_p;

  localparam int W = 16;

  typedef struct {
    logic [15:0] word;
    logic [15:0] exp_line;   // first transmitted bit at MSB
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic en0;
  logic en1;
  logic so0, busy0, und0;
  logic so1, busy1, und1;
  logic [7:0] uc0, uc1;

  serdesphy_ana_serializer_p_if #(.DATA_W(16)) b0 ();
  serdesphy_ana_serializer_p_if #(.DATA_W(10)) b1 ();

  serdesphy_ana_serializer_p #(
    .DATA_W(16), .MSB_FIRST(1'b0), .IDLE_WORD(64'h5555), .INVERT(1'b0)
  ) dut0 (
    .clk_240m(clk), .rst(rst), .enable(en0), .tx_if(b0),
    .serial_out(so0), .busy(busy0), .underrun(und0), .underrun_count(uc0)
  );

  serdesphy_ana_serializer_p #(
    .DATA_W(10), .MSB_FIRST(1'b1), .IDLE_WORD(64'h5555), .INVERT(1'b1)
  ) dut1 (
    .clk_240m(clk), .rst(rst), .enable(en1), .tx_if(b1),
    .serial_out(so1), .busy(busy1), .underrun(und1), .underrun_count(uc1)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state for dut0
  bit          m_run, m_hv, m_und, m_is_data;
  int          m_cnt, m_uc;
  logic [15:0] m_bits;
  logic [15:0] col;
  logic [15:0] q_line[$];
  logic [15:0] q_done[$];
  vec_t        tbl[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_hv = 0; m_und = 0; m_is_data = 0;
    m_cnt = 0; m_uc = 0; m_bits = '0;
    q_line.delete();
  endtask

  task automatic step();
    bit          acc;
    logic [15:0] w;
    acc = (b0.load_data === 1'b1) && en0 && !m_hv;
    w   = b0.parallel_in;
    @(posedge clk); #1;
    if (!en0) begin
      model_reset();
    end else begin
      m_und = 0;
      if (m_hv && (!m_run || m_cnt == W-1)) begin
        if (q_line.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL scoreboard_empty: got 0 expected 1 at %0t", $time);
          m_bits = '0;
        end else begin
          m_bits = q_line.pop_front();
        end
        m_hv = 0; m_run = 1; m_cnt = 0; m_is_data = 1;
      end else if (m_run && m_cnt == W-1) begin
        m_bits = 16'h5555; m_cnt = 0; m_und = 1; m_is_data = 0;
        if (m_uc < 255) m_uc++;
      end else if (m_run) begin
        m_cnt++;
      end
      if (acc) begin
        q_line.push_back(w);
        m_hv = 1;
      end
    end
    check("serial_out", so0, m_run ? m_bits[m_cnt] : 1'b0);
    check("busy", busy0, m_run);
    check("underrun", und0, m_und);
    check("underrun_count", uc0, m_uc);
    check("data_ready", b0.data_ready, en0 & ~m_hv);
    if (m_run && m_is_data) begin
      col[W-1-m_cnt] = so0;
      if (m_cnt == W-1) q_done.push_back(col);
    end
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!(en0 && !m_hv) && k < 100) begin
      step();
      k++;
    end
    if (k >= 100) begin
      n_checks++; n_fail++;
      $display("FAIL wait_ready: got timeout expected data_ready");
    end
  endtask

  task automatic send0(input logic [15:0] word);
    wait_ready();
    b0.load_data   = 1'b1;
    b0.parallel_in = word;
    step();
    b0.load_data   = 1'b0;
  endtask

  task automatic wait_done(input int n);
    int k = 0;
    while (q_done.size() < n && k < 400) begin
      step();
      k++;
    end
    if (k >= 400) begin
      n_checks++; n_fail++;
      $display("FAIL wait_done: got %0d words expected %0d", q_done.size(), n);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] exp1;
    int         base;
    int         k;

    tbl[0] = '{16'hA5C3, 16'b1100001110100101};
    tbl[1] = '{16'h0001, 16'b1000000000000000};
    tbl[2] = '{16'hFFFF, 16'b1111111111111111};
    tbl[3] = '{16'h8000, 16'b0000000000000001};
    tbl[4] = '{16'h1234, 16'b0010110001001000};

    rst = 1'b1; en0 = 1'b0; en1 = 1'b0;
    b0.load_data = 1'b0; b0.parallel_in = '0;
    b1.load_data = 1'b0; b1.parallel_in = '0;
    model_reset();
    #1;
    check("rst_serial0", so0, 1'b0);
    check("rst_busy0", busy0, 1'b0);
    check("rst_underrun0", und0, 1'b0);
    check("rst_count0", uc0, 8'd0);
    check("rst_ready_en0", b0.data_ready, 1'b0);
    check("rst_serial1_inv", so1, 1'b1);
    en0 = 1'b1; en1 = 1'b1;
    #1;
    check("rst_ready0", b0.data_ready, 1'b1);
    check("rst_ready1", b1.data_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;

    // Table: first word from idle, the rest back-to-back
    for (int i = 0; i < 5; i++) send0(tbl[i].word);
    wait_done(5);
    for (int i = 0; i < 5; i++) check("tbl_line", q_done[i], tbl[i].exp_line);
    step();
    check("underrun_pulse", und0, 1'b1);
    check("underrun_count_1", uc0, 8'd1);
    check("idle_bit0", so0, 1'b1);
    step();
    check("idle_bit1", so0, 1'b0);
    check("underrun_one_cycle", und0, 1'b0);
    step();
    check("idle_bit2", so0, 1'b1);

    // Saturation of the underrun counter
    repeat (300 * W) step();
    check("sat_count", uc0, 8'd255);
    check("sat_busy", busy0, 1'b1);

    // Asynchronous reset mid-word
    #2 rst = 1'b1;
    #1;
    check("arst_serial", so0, 1'b0);
    check("arst_busy", busy0, 1'b0);
    check("arst_count", uc0, 8'd0);
    check("arst_ready", b0.data_ready, 1'b1);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Enable drop at bit 7 with a word held
    send0(16'h1111);
    k = 0;
    while (!m_und && k < 100) begin step(); k++; end
    check("pre_drop_count", uc0, 8'd1);
    send0(16'hFFFF);
    send0(16'h0F0F);
    k = 0;
    while (!(m_is_data && m_run && m_cnt == 7 && m_hv) && k < 100) begin step(); k++; end
    check("drop_reach_bit7", k < 100, 1'b1);
    en0 = 1'b0;
    step();
    check("drop_busy", busy0, 1'b0);
    check("drop_serial", so0, 1'b0);
    check("drop_count", uc0, 8'd0);
    check("drop_ready", b0.data_ready, 1'b0);
    en0 = 1'b1;
    #1;
    check("reen_ready", b0.data_ready, 1'b1);
    base = q_done.size();
    send0(16'h00F0);
    wait_done(base + 1);
    if (q_done.size() > base) check("reen_line", q_done[base], 16'b0000111100000000);

    // Second configuration: 10 bits, MSB first, inverted line
    exp1 = 10'b0100001110;
    check("d1_ready", b1.data_ready, 1'b1);
    b1.load_data   = 1'b1;
    b1.parallel_in = 10'h2F1;
    step();
    b1.load_data   = 1'b0;
    check("d1_held_ready", b1.data_ready, 1'b0);
    check("d1_idle_busy", busy1, 1'b0);
    check("d1_idle_serial", so1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step();
      check("d1_bit", so1, exp1[9-i]);
      check("d1_busy", busy1, 1'b1);
    end
    step();
    check("d1_underrun", und1, 1'b1);
    check("d1_count", uc1, 8'd1);
    check("d1_idle_bit0", so1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serdesphy_ana_serializer_p.md
# serdesphy_ana_serializer_p

Parametrised, double-buffered parallel-to-serial converter for the SerDes PHY transmit path. It sits between the TX encoder/framer and the analog TX driver, and accepts one DATA_W-bit word per ready/load handshake. Each word is shifted out one bit per clock in a selectable bit order. When no word is waiting at a word boundary, it fills the line with an idle pattern, flags the underrun and counts it.

## Interface
Parameters:
- DATA_W, 16: word width; legal range 2..64.
- MSB_FIRST, 0: 0 = bit 0 transmitted first; 1 = bit DATA_W-1 transmitted first.
- IDLE_WORD, 'h5555: fill word used on underrun, truncated or zero-extended to DATA_W.
- INVERT, 0: 1 = serial_out is inverted (line polarity swap).

Ports:
- clk_240m, input, 1: 240 MHz transmit bit clock. This is the only clock.
- rst, input, 1: asynchronous, active-high reset.
- enable, input, 1: run enable; 0 forces the IDLE state.
- load_data, input, 1: word-valid strobe from upstream.
- parallel_in, input, DATA_W: word to transmit; sampled only on accept.
- data_ready, output, 1: holding register empty and enable=1.
- serial_out, output, 1: registered serial bit.
- busy, output, 1: 1 while in RUN.
- underrun, output, 1: one-cycle pulse when IDLE_WORD is inserted.
- underrun_count, output, 8: saturating count of underruns.

## Operation
- Internal storage:
  - hold[DATA_W-1:0] and hold_valid form the holding register.
  - sr[DATA_W-1:0] is the shift register.
  - bit_cnt has width clog2(DATA_W).
  - state is IDLE or RUN.
- Accept: an accept occurs on a rising edge where load_data=1 and data_ready=1. On accept, hold <= parallel_in and hold_valid <= 1.
  - data_ready = enable & ~hold_valid. It is driven combinationally from registers, with no path from load_data.
  - load_data while data_ready=0 is ignored. The word is dropped and no error is raised; upstream must honour data_ready.
- IDLE state:
  - sr = 0, bit_cnt = 0, serial_out = INVERT.
  - Goes to RUN when enable=1 and hold_valid=1. On that transition: sr <= hold, hold_valid <= 0, bit_cnt <= 0.
- RUN state: the current bit is sr[0] when MSB_FIRST=0, or sr[DATA_W-1] when MSB_FIRST=1.
  - If bit_cnt < DATA_W-1: shift sr toward the output end and increment bit_cnt.
  - If bit_cnt == DATA_W-1 (word boundary) and hold_valid=1: sr <= hold, hold_valid <= 0, bit_cnt <= 0. There is no gap bit.
  - If bit_cnt == DATA_W-1 and hold_valid=0: sr <= IDLE_WORD, bit_cnt <= 0, underrun pulses for one cycle, underrun_count increments (saturates at 255). State stays RUN.
- A boundary transfer and an accept never happen on the same edge. data_ready is 0 while hold_valid=1, so the refill is accepted on the following edge. Because DATA_W ≥ 2, full throughput is still sustained.
- enable=0 in any state:
  - On the next edge go to IDLE, clear sr, bit_cnt, hold_valid and underrun, and clear underrun_count.
  - The word in flight and the held word are discarded.
- busy = (state == RUN).

## Timing
- Reset values: serial_out = INVERT, busy = 0, underrun = 0, underrun_count = 0, data_ready = enable (hold_valid = 0).
- Reset is asynchronous: the same values apply immediately on rst assertion, including mid-word. Reset removal is synchronised externally.
- Latency from IDLE:
  - The accept at edge E0 sets hold_valid.
  - Edge E1 loads sr and enters RUN; the first bit is on serial_out after E1.
  - Each following edge presents the next bit. The last bit of the word is valid after edge E1+DATA_W-1.
- Steady state: one word every DATA_W cycles, with back-to-back words contiguous on the line.
- underrun asserts in the cycle whose edge loaded IDLE_WORD, i.e. coincident with the first idle bit.
- serial_out is taken directly from a flop (sr bit, XOR with INVERT folded in).

## Test plan
- Reset: assert rst mid-word with enable=1 -> serial_out=0, busy=0, underrun_count=0 immediately; data_ready=1.
- Single word, DATA_W=16, LSB first: load 16'hA5C3 -> bits 1100001110100101 on the 16 cycles starting 2 edges after accept; then one underrun pulse, underrun_count=1, and IDLE_WORD bits 1010... follow.
- Back-to-back: load 16'h0001 then 16'hFFFF as soon as data_ready rises -> 1 followed by fifteen 0s, then sixteen 1s with no gap and no underrun.
- Underrun saturation: one word, then no loads for 300×16 cycles -> underrun_count stops at 255, busy stays 1.
- Enable drop: drop enable at bit 7 of a word with hold_valid=1 -> IDLE on the next edge, serial_out=0, hold cleared, underrun_count=0; re-enabling with a new word restarts from bit 0.
- DATA_W=10, MSB_FIRST=1, INVERT=1: load 10'h2F1 -> serial_out sequence 0100001110 (the complement of 1011110001).
